// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32 subset control FSM: fetch/decode/exec/mem/writeback with
// memory-wait timeout and an absorbing trap state.
module mc_ctrl_fsm #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        Branch,
  output logic [4:0]  ALUop,
  output logic        Asel,
  output logic        Bsel,
  output logic [2:0]  imm_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        halt,
  output logic        fault,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel
);

  localparam int CW = $clog2(MAX_WAIT + 1) + 1;

  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_SLL = 5'b00010,
                         ALU_SRL = 5'b00011, ALU_OR  = 5'b00100, ALU_AND = 5'b00101,
                         ALU_XOR = 5'b00110, ALU_SRA = 5'b00111, ALU_BEQ = 5'b01000,
                         ALU_BNE = 5'b01001, ALU_BLT = 5'b01010, ALU_BGE = 5'b01011,
                         ALU_LUI = 5'b01100;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_ir;
  logic [CW-1:0]   r_cnt;
  logic            w_at_limit;

  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  logic       w_legal, w_asel, w_bsel, w_is_lw, w_is_sw, w_is_br, w_is_jal;
  logic [4:0] w_aluop;
  logic [2:0] w_imm_sel;
  logic       w_unused;

  assign w_op       = r_ir[6:0];
  assign w_f3       = r_ir[14:12];
  assign w_f7       = r_ir[31:25];
  assign w_unused   = ^{r_ir[24:15], r_ir[11:7]};
  assign w_at_limit = (r_cnt == CW'(MAX_WAIT));

  // Instruction decode from the latched IR only, so outputs never follow instr.
  always_comb begin
    w_legal = 1'b0; w_aluop = ALU_ADD; w_asel = 1'b1; w_bsel = 1'b0; w_imm_sel = 3'd0;
    w_is_lw = 1'b0; w_is_sw = 1'b0; w_is_br = 1'b0; w_is_jal = 1'b0;
    case (w_op)
      7'b0110011: begin
        w_bsel = 1'b1;
        if (w_f7 == 7'b0000000) begin
          w_legal = 1'b1;
          case (w_f3)
            3'b000:  w_aluop = ALU_ADD;
            3'b001:  w_aluop = ALU_SLL;
            3'b100:  w_aluop = ALU_XOR;
            3'b101:  w_aluop = ALU_SRL;
            3'b110:  w_aluop = ALU_OR;
            3'b111:  w_aluop = ALU_AND;
            default: w_legal = 1'b0;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
          w_aluop = (w_f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end
      end
      7'b0010011: begin
        w_legal = 1'b1;
        case (w_f3)
          3'b000:  w_aluop = ALU_ADD;
          3'b100:  w_aluop = ALU_XOR;
          3'b110:  w_aluop = ALU_OR;
          3'b111:  w_aluop = ALU_AND;
          3'b001: begin w_aluop = ALU_SLL; w_legal = (w_f7 == 7'b0000000); end
          3'b101: begin
            w_aluop = (w_f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          end
          default: w_legal = 1'b0;
        endcase
      end
      7'b0000011: begin w_legal = (w_f3 == 3'b010); w_is_lw = 1'b1; end
      7'b0100011: begin w_legal = (w_f3 == 3'b010); w_is_sw = 1'b1; w_imm_sel = 3'd1; end
      7'b1100011: begin
        w_bsel = 1'b1; w_imm_sel = 3'd2; w_is_br = 1'b1; w_legal = 1'b1;
        case (w_f3)
          3'b000:  w_aluop = ALU_BEQ;
          3'b001:  w_aluop = ALU_BNE;
          3'b100:  w_aluop = ALU_BLT;
          3'b101:  w_aluop = ALU_BGE;
          default: w_legal = 1'b0;
        endcase
      end
      7'b0110111: begin w_legal = 1'b1; w_asel = 1'b0; w_aluop = ALU_LUI; w_imm_sel = 3'd3; end
      7'b0010111: begin w_legal = 1'b1; w_asel = 1'b0; w_imm_sel = 3'd3; end
      7'b1101111: begin w_legal = 1'b1; w_asel = 1'b0; w_imm_sel = 3'd4; w_is_jal = 1'b1; end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_FETCH && imem_ready) r_ir <= instr;
      if (w_state_next != r_state)                    r_cnt <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM) r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  if (imem_ready) w_state_next = S_DECODE;
                else if (w_at_limit) w_state_next = S_TRAP;
      S_DECODE: w_state_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC:   w_state_next = w_is_br ? S_FETCH : ((w_is_lw || w_is_sw) ? S_MEM : S_WB);
      S_MEM:    if (dmem_ready) w_state_next = w_is_sw ? S_FETCH : S_WB;
                else if (w_at_limit) w_state_next = S_TRAP;
      S_WB:     w_state_next = S_FETCH;
      default:  w_state_next = S_TRAP;
    endcase
  end

  // The branch target select and the store's PC update are qualified by
  // Branch/dmem_ready in-cycle; everything else depends only on state and IR.
  always_comb begin
    ALUop = '0; Asel = 1'b0; Bsel = 1'b0; imm_sel = '0;
    ir_we = 1'b0; pc_we = 1'b0; reg_we = 1'b0; imem_req = 1'b0;
    dmem_req = 1'b0; dmem_we = 1'b0; halt = 1'b0; fault = 1'b0;
    pc_sel = '0; wb_sel = '0;
    if (!rst) begin
      if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
        ALUop = w_aluop; Asel = w_asel; Bsel = w_bsel; imm_sel = w_imm_sel;
      end
      case (r_state)
        S_FETCH: begin imem_req = 1'b1; ir_we = 1'b1; end
        S_EXEC: if (w_is_br) begin pc_we = 1'b1; pc_sel = {1'b0, Branch}; end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = w_is_sw;
          pc_we    = w_is_sw && dmem_ready;
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          wb_sel = w_is_lw ? 2'd1 : (w_is_jal ? 2'd2 : 2'd0);
          pc_sel = w_is_jal ? 2'd1 : 2'd0;
        end
        S_TRAP: begin halt = 1'b1; fault = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule
